// File: rtl/mismatch_monitor_pkg.sv
// Shared types and helpers for the mismatch monitor.
package mismatch_monitor_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Widest counter the saturating helper supports.
  localparam int unsigned SAT_W = 32;

  // Saturating increment of a value held in the low 'width' bits.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] value,
                                               input int unsigned     width);
    logic [SAT_W:0] limit;
    limit = ((SAT_W+1)'(1) << width) - (SAT_W+1)'(1);
    if ({1'b0, value} >= limit) sat_inc = value;
    else                        sat_inc = value + SAT_W'(1);
  endfunction

endpackage

// File: rtl/mismatch_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter
  import mismatch_monitor_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  logic [CNT_W-1:0] q_d;
  logic [CNT_W-1:0] q_q;

  // Next count: clear, saturating step, or hold.
  always_comb begin
    q_d = q_q;
    if (clr)      q_d = '0;
    else if (inc) q_d = CNT_W'(sat_inc(SAT_W'(q_q), CNT_W));
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/mismatch_monitor.sv
// Response checker: compares DUT words against reference words, counts
// samples and mismatches, records the first failure and reports a verdict.
module mismatch_monitor
  import mismatch_monitor_pkg::*;
#(
  parameter int WIDTH     = 1,
  parameter int CNT_W     = 16,
  parameter int N_SAMPLES = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] dut_val,
  input  logic [WIDTH-1:0] ref_val,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             mismatch,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             first_err_vld,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [WIDTH-1:0] first_err_dut,
  output logic [WIDTH-1:0] first_err_ref
);

  state_t           state_d, state_q;
  logic             mismatch_d, mismatch_q;
  logic             first_err_vld_d, first_err_vld_q;
  logic [CNT_W-1:0] first_err_idx_d, first_err_idx_q;
  logic [WIDTH-1:0] first_err_dut_d, first_err_dut_q;
  logic [WIDTH-1:0] first_err_ref_d, first_err_ref_q;

  logic accept;
  logic differ;
  logic last_sample;

  // A sample counts only while running and never in a clearing cycle; X/Z
  // on either side is treated as a difference.
  assign accept      = (state_q == S_RUN) && sample_valid && !start;
  assign differ      = (dut_val !== ref_val);
  assign last_sample = (N_SAMPLES != 0) &&
                       (sat_inc(SAT_W'(sample_cnt), CNT_W) == SAT_W'(N_SAMPLES));

  sat_counter #(.CNT_W(CNT_W)) u_sample_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start),
    .inc   (accept),
    .q     (sample_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_mismatch_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start),
    .inc   (accept && differ),
    .q     (mismatch_cnt)
  );

  // Run control: start always (re)arms; a run ends on stop or the final sample.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = S_RUN;
    end else if ((state_q == S_RUN) && (stop || (accept && last_sample))) begin
      state_d = S_DONE;
    end
  end

  // Per-sample flag and first-failure capture; later failures never overwrite.
  always_comb begin
    mismatch_d      = mismatch_q;
    first_err_vld_d = first_err_vld_q;
    first_err_idx_d = first_err_idx_q;
    first_err_dut_d = first_err_dut_q;
    first_err_ref_d = first_err_ref_q;
    if (start) begin
      mismatch_d      = 1'b0;
      first_err_vld_d = 1'b0;
      first_err_idx_d = '0;
      first_err_dut_d = '0;
      first_err_ref_d = '0;
    end else if (accept) begin
      mismatch_d = differ;
      if (differ && !first_err_vld_q) begin
        first_err_vld_d = 1'b1;
        first_err_idx_d = sample_cnt;
        first_err_dut_d = dut_val;
        first_err_ref_d = ref_val;
      end
    end
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      mismatch_q      <= 1'b0;
      first_err_vld_q <= 1'b0;
      first_err_idx_q <= '0;
      first_err_dut_q <= '0;
      first_err_ref_q <= '0;
    end else begin
      state_q         <= state_d;
      mismatch_q      <= mismatch_d;
      first_err_vld_q <= first_err_vld_d;
      first_err_idx_q <= first_err_idx_d;
      first_err_dut_q <= first_err_dut_d;
      first_err_ref_q <= first_err_ref_d;
    end
  end

  assign busy          = (state_q == S_RUN);
  assign done          = (state_q == S_DONE);
  assign pass          = done && (mismatch_cnt == '0) && (sample_cnt != '0);
  assign mismatch      = mismatch_q;
  assign first_err_vld = first_err_vld_q;
  assign first_err_idx = first_err_idx_q;
  assign first_err_dut = first_err_dut_q;
  assign first_err_ref = first_err_ref_q;

endmodule

// File: tb/tb_mismatch_monitor.sv
// Scoreboard bench for mismatch_monitor: three instances share stimulus
// (default, unbounded run, 3-bit counters) and each scenario checks one.
module tb_mismatch_monitor;

  logic       clk = 1'b0;
  logic       rst_n, start, stop, sample_valid;
  logic [0:0] dut_val, ref_val;

  logic        a_busy, a_done, a_pass, a_mismatch, a_fev, a_fed, a_fer;
  logic [15:0] a_scnt, a_mcnt, a_fei;
  logic        b_busy, b_done, b_pass, b_mismatch, b_fev, b_fed, b_fer;
  logic [15:0] b_scnt, b_mcnt, b_fei;
  logic        c_busy, c_done, c_pass, c_mismatch, c_fev, c_fed, c_fer;
  logic [2:0]  c_scnt, c_mcnt, c_fei;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        mis;
    logic [15:0] cnt;
    logic [15:0] mcnt;
  } exp_t;
  exp_t sb[$];

  mismatch_monitor #(.WIDTH(1), .CNT_W(16), .N_SAMPLES(11)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .sample_valid(sample_valid),
    .dut_val(dut_val), .ref_val(ref_val), .busy(a_busy), .done(a_done), .pass(a_pass),
    .mismatch(a_mismatch), .sample_cnt(a_scnt), .mismatch_cnt(a_mcnt), .first_err_vld(a_fev),
    .first_err_idx(a_fei), .first_err_dut(a_fed), .first_err_ref(a_fer));

  mismatch_monitor #(.WIDTH(1), .CNT_W(16), .N_SAMPLES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .sample_valid(sample_valid),
    .dut_val(dut_val), .ref_val(ref_val), .busy(b_busy), .done(b_done), .pass(b_pass),
    .mismatch(b_mismatch), .sample_cnt(b_scnt), .mismatch_cnt(b_mcnt), .first_err_vld(b_fev),
    .first_err_idx(b_fei), .first_err_dut(b_fed), .first_err_ref(b_fer));

  mismatch_monitor #(.WIDTH(1), .CNT_W(3), .N_SAMPLES(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .sample_valid(sample_valid),
    .dut_val(dut_val), .ref_val(ref_val), .busy(c_busy), .done(c_done), .pass(c_pass),
    .mismatch(c_mismatch), .sample_cnt(c_scnt), .mismatch_cnt(c_mcnt), .first_err_vld(c_fev),
    .first_err_idx(c_fei), .first_err_dut(c_fed), .first_err_ref(c_fer));

  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; sample_valid = 1'b0;
    dut_val = 1'b0; ref_val = 1'b0;
    #2;
    n_cmp++; if (a_busy !== 1'b0) begin n_err++; $display("[TB] FAIL reset_busy: got %0b want 0", a_busy); end
    n_cmp++; if (a_done !== 1'b0) begin n_err++; $display("[TB] FAIL reset_done: got %0b want 0", a_done); end
    n_cmp++; if (a_pass !== 1'b0) begin n_err++; $display("[TB] FAIL reset_pass: got %0b want 0", a_pass); end
    n_cmp++; if (a_mismatch !== 1'b0) begin n_err++; $display("[TB] FAIL reset_mismatch: got %0b want 0", a_mismatch); end
    n_cmp++; if (a_scnt !== 16'd0) begin n_err++; $display("[TB] FAIL reset_sample_cnt: got %0d want 0", a_scnt); end
    n_cmp++; if (a_mcnt !== 16'd0) begin n_err++; $display("[TB] FAIL reset_mismatch_cnt: got %0d want 0", a_mcnt); end
    n_cmp++; if ({a_fev, a_fei, a_fed, a_fer} !== 19'd0) begin n_err++; $display("[TB] FAIL reset_first_err: got %0h want 0", {a_fev, a_fei, a_fed, a_fer}); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Golden run of 11 samples, optionally forcing the DUT side high on samples 2 and 5.
  task automatic test_golden_run(input bit inject);
    bit   a_in[11] = '{0, 1, 1, 0, 1, 0, 1, 1, 0, 1, 1};
    bit   b_in[11] = '{1, 1, 0, 0, 0, 1, 1, 0, 0, 1, 0};
    int   m_cnt = 0;
    int   m_mcnt = 0;
    logic d, r, mis;
    exp_t e;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 11; i++) begin
      r = a_in[i] & b_in[i];
      d = (inject && (i == 2 || i == 5)) ? 1'b1 : r;
      mis = (d !== r);
      sample_valid = 1'b1; dut_val = d; ref_val = r;
      m_cnt++; if (mis) m_mcnt++;
      sb.push_back('{mis: mis, cnt: 16'(m_cnt), mcnt: 16'(m_mcnt)});
      tick();
      e = sb.pop_front();
      n_cmp++; if (a_mismatch !== e.mis) begin n_err++; $display("[TB] FAIL golden_mismatch[%0d]: got %0b want %0b", i, a_mismatch, e.mis); end
      n_cmp++; if (a_scnt !== e.cnt) begin n_err++; $display("[TB] FAIL golden_sample_cnt[%0d]: got %0d want %0d", i, a_scnt, e.cnt); end
      n_cmp++; if (a_mcnt !== e.mcnt) begin n_err++; $display("[TB] FAIL golden_mismatch_cnt[%0d]: got %0d want %0d", i, a_mcnt, e.mcnt); end
      n_cmp++; if (a_busy !== (i < 10)) begin n_err++; $display("[TB] FAIL golden_busy[%0d]: got %0b want %0b", i, a_busy, (i < 10)); end
    end
    sample_valid = 1'b0;
    n_cmp++; if (a_done !== 1'b1) begin n_err++; $display("[TB] FAIL golden_done: got %0b want 1", a_done); end
    n_cmp++; if (a_pass !== !inject) begin n_err++; $display("[TB] FAIL golden_pass: got %0b want %0b", a_pass, !inject); end
    n_cmp++; if (a_mcnt !== (inject ? 16'd2 : 16'd0)) begin n_err++; $display("[TB] FAIL golden_total_mismatch: got %0d want %0d", a_mcnt, inject ? 2 : 0); end
    n_cmp++; if (a_fev !== inject) begin n_err++; $display("[TB] FAIL golden_first_err_vld: got %0b want %0b", a_fev, inject); end
    if (inject) begin
      n_cmp++; if (a_fei !== 16'd2) begin n_err++; $display("[TB] FAIL first_err_idx: got %0d want 2", a_fei); end
      n_cmp++; if (a_fed !== 1'b1) begin n_err++; $display("[TB] FAIL first_err_dut: got %0b want 1", a_fed); end
      n_cmp++; if (a_fer !== 1'b0) begin n_err++; $display("[TB] FAIL first_err_ref: got %0b want 0", a_fer); end
    end
    sample_valid = 1'b1; dut_val = 1'b1; ref_val = 1'b0;
    tick();
    sample_valid = 1'b0;
    n_cmp++; if (a_scnt !== 16'd11) begin n_err++; $display("[TB] FAIL golden_done_ignores_sample: got %0d want 11", a_scnt); end
  endtask

  // Unbounded run ended by stop together with the fourth sample.
  task automatic test_stop_with_sample();
    exp_t e;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sample_valid = 1'b1; dut_val = 1'b1; ref_val = 1'b1;
      stop = (i == 3);
      sb.push_back('{mis: 1'b0, cnt: 16'(i + 1), mcnt: 16'd0});
      tick();
      e = sb.pop_front();
      n_cmp++; if (b_scnt !== e.cnt) begin n_err++; $display("[TB] FAIL stop_sample_cnt[%0d]: got %0d want %0d", i, b_scnt, e.cnt); end
    end
    stop = 1'b0;
    n_cmp++; if (b_done !== 1'b1) begin n_err++; $display("[TB] FAIL stop_done: got %0b want 1", b_done); end
    n_cmp++; if (b_pass !== 1'b1) begin n_err++; $display("[TB] FAIL stop_pass: got %0b want 1", b_pass); end
    dut_val = 1'b0; ref_val = 1'b1;
    tick();
    sample_valid = 1'b0;
    n_cmp++; if (b_scnt !== 16'd4) begin n_err++; $display("[TB] FAIL stop_extra_sample_cnt: got %0d want 4", b_scnt); end
    n_cmp++; if (b_mcnt !== 16'd0) begin n_err++; $display("[TB] FAIL stop_extra_mismatch_cnt: got %0d want 0", b_mcnt); end
  endtask

  // 3-bit counters must stick at 7 over ten failing samples.
  task automatic test_saturation();
    exp_t e;
    int   sat;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sample_valid = 1'b1; dut_val = 1'b1; ref_val = 1'b0;
      sat = (i + 1 > 7) ? 7 : i + 1;
      sb.push_back('{mis: 1'b1, cnt: 16'(sat), mcnt: 16'(sat)});
      tick();
      e = sb.pop_front();
      n_cmp++; if ({13'd0, c_scnt} !== e.cnt) begin n_err++; $display("[TB] FAIL sat_sample_cnt[%0d]: got %0d want %0d", i, c_scnt, e.cnt); end
      n_cmp++; if ({13'd0, c_mcnt} !== e.mcnt) begin n_err++; $display("[TB] FAIL sat_mismatch_cnt[%0d]: got %0d want %0d", i, c_mcnt, e.mcnt); end
    end
    sample_valid = 1'b0;
    n_cmp++; if (c_fei !== 3'd0) begin n_err++; $display("[TB] FAIL sat_first_err_idx: got %0d want 0", c_fei); end
    n_cmp++; if (c_fev !== 1'b1) begin n_err++; $display("[TB] FAIL sat_first_err_vld: got %0b want 1", c_fev); end
    stop = 1'b1; tick(); stop = 1'b0;
    n_cmp++; if ({c_done, c_pass} !== 2'b10) begin n_err++; $display("[TB] FAIL sat_verdict: got %b want 10", {c_done, c_pass}); end
  endtask

  // Restart mid-run discards the coincident sample; async reset clears at once.
  task automatic test_start_clears();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample_valid = 1'b1; dut_val = 1'b1; ref_val = 1'b0;
      tick();
    end
    n_cmp++; if (a_mcnt !== 16'd3) begin n_err++; $display("[TB] FAIL restart_precount: got %0d want 3", a_mcnt); end
    start = 1'b1;
    tick();
    start = 1'b0; sample_valid = 1'b0;
    n_cmp++; if (a_scnt !== 16'd0) begin n_err++; $display("[TB] FAIL restart_sample_cnt: got %0d want 0", a_scnt); end
    n_cmp++; if (a_mcnt !== 16'd0) begin n_err++; $display("[TB] FAIL restart_mismatch_cnt: got %0d want 0", a_mcnt); end
    n_cmp++; if ({a_mismatch, a_fev} !== 2'b00) begin n_err++; $display("[TB] FAIL restart_flags: got %b want 00", {a_mismatch, a_fev}); end
    n_cmp++; if (a_busy !== 1'b1) begin n_err++; $display("[TB] FAIL restart_busy: got %0b want 1", a_busy); end
    sample_valid = 1'b1; dut_val = 1'b0; ref_val = 1'b1;
    tick();
    sample_valid = 1'b0;
    n_cmp++; if (a_scnt !== 16'd1) begin n_err++; $display("[TB] FAIL restart_resume: got %0d want 1", a_scnt); end
    rst_n = 1'b0;
    #2;
    n_cmp++; if ({a_busy, a_mismatch, a_fev, a_scnt, a_mcnt} !== 35'd0) begin n_err++; $display("[TB] FAIL async_reset: got %0h want 0", {a_busy, a_mismatch, a_fev, a_scnt, a_mcnt}); end
    rst_n = 1'b1;
    tick();
  endtask

  // Unknown DUT bit counts as a difference; an empty run cannot pass.
  task automatic test_x_and_empty();
    logic xv;
    logic exp_mis;
    xv = 1'bx;
    exp_mis = (xv !== 1'b0);
    start = 1'b1; tick(); start = 1'b0;
    sample_valid = 1'b1; dut_val = xv; ref_val = 1'b0;
    tick();
    sample_valid = 1'b0; dut_val = 1'b0;
    n_cmp++; if (a_mismatch !== exp_mis) begin n_err++; $display("[TB] FAIL x_mismatch: got %0b want %0b", a_mismatch, exp_mis); end
    n_cmp++; if (a_mcnt !== 16'(exp_mis)) begin n_err++; $display("[TB] FAIL x_mismatch_cnt: got %0d want %0d", a_mcnt, exp_mis); end
    start = 1'b1; tick(); start = 1'b0;
    stop = 1'b1; tick(); stop = 1'b0;
    n_cmp++; if (a_done !== 1'b1) begin n_err++; $display("[TB] FAIL empty_done: got %0b want 1", a_done); end
    n_cmp++; if (a_pass !== 1'b0) begin n_err++; $display("[TB] FAIL empty_pass: got %0b want 0", a_pass); end
    n_cmp++; if (a_scnt !== 16'd0) begin n_err++; $display("[TB] FAIL empty_sample_cnt: got %0d want 0", a_scnt); end
  endtask

  initial begin
    test_reset();
    test_golden_run(1'b0);
    test_golden_run(1'b1);
    test_stop_with_sample();
    test_saturation();
    test_start_clears();
    test_x_and_empty();
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("[TB] FAIL scoreboard_drain: got %0d want 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
